// File: rtl/mems_pkg.sv
// Shared MEMS definitions: frame width used by the sequencer, the DAC command ROM and the SPI master,
// plus the SPI master state encoding.
package mems_pkg;

    localparam int MEMS_WORD_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/mems_spi_tick.sv
// Reloadable down-counter; tick is high in the last cycle of a loaded interval of load_val cycles.
module mems_spi_tick #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - CNT_W'(1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/mems_spi_master.sv
// Write-only SPI master for the MEMS mirror DAC: one frame of WORD_W bits, MSB first,
// SCLK idle high, DIN changed on SCLK rise so it is stable at every SCLK fall.
module mems_spi_master
    import mems_pkg::*;
#(
    parameter int WORD_W   = MEMS_WORD_W,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int MIN_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              spi_sync_n,
    output logic              spi_sclk,
    output logic              spi_mosi
);

    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, MIN_GAP) + 1);
    localparam int BIT_W = $clog2(WORD_W);

    spi_state_t        state;
    spi_state_t        state_next;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              phase_high;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tick;

    mems_spi_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every timed state reloads the tick counter on entry, so no counter ever wraps.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_SETUP;
                tmr_load   = 1'b1;
                tmr_val    = CNT_W'(CS_SETUP);
            end
            ST_SETUP: begin
                tmr_en = 1'b1;
                if (tick) begin
                    state_next = ST_SHIFT;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(CLK_DIV);
                end
            end
            ST_SHIFT: begin
                tmr_en = 1'b1;
                if (tick) begin
                    tmr_load = 1'b1;
                    if (phase_high && (bit_cnt == '0)) begin
                        state_next = ST_HOLD;
                        tmr_val    = CNT_W'(CS_HOLD);
                    end else begin
                        tmr_val = CNT_W'(CLK_DIV);
                    end
                end
            end
            ST_HOLD: begin
                tmr_en = 1'b1;
                if (tick) begin
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(MIN_GAP);
                end
            end
            ST_GAP: begin
                tmr_en = 1'b1;
                if (tick) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_sync_n <= 1'b1;
            spi_sclk   <= 1'b1;
            spi_mosi   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            phase_high <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state == ST_GAP) && (state_next == ST_IDLE);
            case (state)
                ST_LOAD: begin
                    shreg      <= data_in;
                    spi_mosi   <= data_in[WORD_W-1];
                    spi_sync_n <= 1'b0;
                end
                ST_SETUP: begin
                    if (tick) begin
                        spi_sclk   <= 1'b0;
                        phase_high <= 1'b0;
                        bit_cnt    <= BIT_W'(WORD_W - 1);
                    end
                end
                ST_SHIFT: begin
                    // Next bit goes out on the rising edge, a full half-period before the DAC samples it.
                    if (tick) begin
                        if (!phase_high) begin
                            spi_sclk   <= 1'b1;
                            phase_high <= 1'b1;
                            shreg      <= {shreg[WORD_W-2:0], 1'b0};
                            spi_mosi   <= shreg[WORD_W-2];
                        end else if (bit_cnt != '0) begin
                            spi_sclk   <= 1'b0;
                            phase_high <= 1'b0;
                            bit_cnt    <= bit_cnt - BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) spi_sync_n <= 1'b1;
                end
                ST_IDLE, ST_GAP: begin
                end
                default: begin
                    spi_sync_n <= 1'b1;
                    spi_sclk   <= 1'b1;
                    spi_mosi   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mems_spi_master.sv
// Bench for mems_spi_master: random and directed frames checked against a cycle-count reference model
// and a DAC receiver model that samples DIN on SCLK falls.
`timescale 1ns/1ps
module tb_mems_spi_master;

    localparam int W          = 24;
    localparam int BUSY_LEN   = 1 + 2 + 2 * 2 * W + 2 + 4;
    localparam int BUSY_LEN_B = 1 + 1 + 2 * 1 * W + 1 + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy, done, sync_n, sclk, mosi;
    logic         start_b;
    logic [W-1:0] data_b;
    logic         busy_b, done_b, sync_b, sclk_b, mosi_b;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    mems_spi_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .spi_sync_n (sync_n),
        .spi_sclk   (sclk),
        .spi_mosi   (mosi)
    );

    mems_spi_master #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .MIN_GAP  (1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .data_in    (data_b),
        .busy       (busy_b),
        .done       (done_b),
        .spi_sync_n (sync_b),
        .spi_sclk   (sclk_b),
        .spi_mosi   (mosi_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: a frame occupies BUSY_LEN cycles after its accept edge; the next accept
    // is possible in the first idle (done) cycle. The word is data_in one cycle after accept.
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_cap  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_cap  = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_cap) begin
                exp_q.push_back(data_in);
                m_cap = 1'b0;
            end
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt = BUSY_LEN;
                    m_cap = 1'b1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_cnt != 0));
        check("done", 32'(done), 32'(m_done));
        if (m_cnt == 0) begin
            check("idle_sync_n", 32'(sync_n), 32'd1);
            check("idle_sclk", 32'(sclk), 32'd1);
        end
    end

    // DAC receiver models
    logic [W-1:0] rx = '0;
    int           nbits = 0;
    logic [W-1:0] rx_b = '0;
    int           nbits_b = 0;
    int           frames_b = 0;

    always @(negedge sync_n) begin
        rx    = '0;
        nbits = 0;
    end

    always @(negedge sclk) begin
        if (rst_n && !sync_n) begin
            rx = {rx[W-2:0], mosi};
            nbits++;
        end
    end

    always @(posedge sync_n) begin
        logic [W-1:0] w;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'(rx), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("frame_word", 32'(rx), 32'(w));
                check("frame_bits", 32'(nbits), 32'(W));
            end
        end
    end

    always @(negedge sync_b) begin
        rx_b    = '0;
        nbits_b = 0;
    end

    always @(negedge sclk_b) begin
        if (rst_n && !sync_b) begin
            rx_b = {rx_b[W-2:0], mosi_b};
            nbits_b++;
        end
    end

    always @(posedge sync_b) begin
        if (rst_n) frames_b++;
    end

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && (k < max_cyc)) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] words[3];
        int           k;
        int           cnt;
        words   = '{24'h280001, 24'h380000, 24'h1822AA};
        start   = 1'b0;
        data_in = '0;
        start_b = 1'b0;
        data_b  = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with start toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start   = i[0];
            data_in = W'($urandom);
        end
        @(negedge clk);
        check("rst_sync_n", 32'(sync_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Single frame; data changes after capture must not matter
        @(negedge clk);
        start   = 1'b1;
        data_in = '0;
        @(negedge clk);
        start   = 1'b0;
        data_in = 24'hA5C3F0;
        @(negedge clk);
        data_in = W'($urandom);
        wait_idle(300);

        // Sequencer-style driver
        for (int i = 0; i < 3; i++) begin
            start   = 1'b1;
            data_in = W'($urandom);
            @(negedge clk);
            start   = 1'b0;
            data_in = words[i];
            @(negedge clk);
            check("seq_busy_first_check", 32'(busy), 32'd1);
            data_in = W'($urandom);
            wait_idle(300);
        end

        // start held high with incrementing data
        k = int'($urandom_range(0, 1000));
        for (int i = 0; i < 300; i++) begin
            start   = 1'b1;
            data_in = W'(k + i);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle(300);

        // Abort after the 10th SCLK fall, then a clean frame
        start   = 1'b1;
        data_in = W'($urandom);
        @(negedge clk);
        start   = 1'b0;
        data_in = W'($urandom);
        k = 0;
        while (!(!sync_n && (nbits >= 10)) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_10_falls", 32'(nbits >= 10), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sync_n", 32'(sync_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        data_in = W'($urandom);
        @(negedge clk);
        start   = 1'b0;
        data_in = 24'h3FFFFF;
        @(negedge clk);
        data_in = W'($urandom);
        wait_idle(300);

        // Minimum timing parameters
        @(negedge clk);
        start_b = 1'b1;
        data_b  = '0;
        cnt     = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_b = 1'b0;
                data_b  = 24'hA5C3F0;
            end else if (i == 1) begin
                data_b = W'($urandom);
            end
            if (!busy_b) break;
            cnt++;
        end
        check("fast_busy_len", 32'(cnt), 32'(BUSY_LEN_B));
        check("fast_done", 32'(done_b), 32'd1);
        check("fast_word", 32'(rx_b), 32'h00A5C3F0);
        check("fast_bits", 32'(nbits_b), 32'(W));
        check("fast_frames", 32'(frames_b), 32'd1);

        repeat (2) @(negedge clk);
        check("all_frames_received", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
